// File: rtl/tdot_pkg.sv
// Shared defaults, pipeline latency and operand slice helpers for the tdot feeder.
package tdot_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LANES = 5;
  localparam int DEF_TERMS = 3;
  localparam int BIAS_SKEW = 2;

  // Acceptance-to-result distance, in advance cycles.
  function automatic int lat_for(input int terms);
    return terms + 2;
  endfunction

  localparam int LAT = lat_for(DEF_TERMS);

  function automatic int term_lsb(input int t, input int lanes, input int width);
    return t * lanes * width;
  endfunction

  function automatic int term_lane_lsb(input int t, input int l, input int lanes, input int width);
    return (t * lanes + l) * width;
  endfunction

endpackage

// File: rtl/tdot_skew.sv
// Enabled delay line of DEPTH stages with synchronous clear; DEPTH = 0 is a plain wire.
module tdot_skew #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clock, reset, en};
    assign q = d;
  end else begin : g_line
    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clock) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/tdot_feeder.sv
// Feeds skewed vector jobs into the tdot systolic array and collects its results.
// Define TDOT_FEEDER_PERF_EN to add the perf_done / perf_stall counters.
module tdot_feeder
  import tdot_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int TERMS = DEF_TERMS
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [TERMS*LANES*WIDTH-1:0] s_a,
  input  logic [TERMS*LANES*WIDTH-1:0] s_b,
  input  logic [LANES*WIDTH-1:0]       s_bias,
  output logic [TERMS*LANES*WIDTH-1:0] dot_a,
  output logic [TERMS*LANES*WIDTH-1:0] dot_b,
  output logic [LANES*WIDTH-1:0]       dot_bias,
  output logic                         dot_en,
  input  logic [LANES*WIDTH-1:0]       dot_res,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [LANES*WIDTH-1:0]       m_data,
  output logic                         busy
`ifdef TDOT_FEEDER_PERF_EN
  ,
  output logic [31:0]                  perf_done,
  output logic [31:0]                  perf_stall
`endif
);

  localparam int PL = lat_for(TERMS);
  localparam int LW = LANES * WIDTH;
  localparam int CW = $clog2(PL + 1);

  // Both sides transfer a beat on valid && ready. Ready on either side depends
  // only on whether the pipeline advances, and advancing is blocked solely by a
  // held result (m_valid && !m_ready), which freezes the whole datapath.
  logic adv;
  logic accept;
  logic done;

  assign adv    = !m_valid || m_ready;
  assign dot_en = adv;
  assign s_ready = adv;
  assign accept = s_valid && adv;
  assign done   = m_valid && m_ready;

  // Bubbles inject zeros so the array accumulates nothing for empty slots.
  logic [TERMS*LW-1:0] a_in;
  logic [TERMS*LW-1:0] b_in;
  logic [LW-1:0]       bias_in;

  assign a_in    = s_valid ? s_a : '0;
  assign b_in    = s_valid ? s_b : '0;
  assign bias_in = s_valid ? s_bias : '0;

  for (genvar t = 0; t < TERMS; t++) begin : g_term
    tdot_skew #(.DEPTH(t), .W(LW)) u_skew_a (
      .clock (clock),
      .reset (reset),
      .en    (adv),
      .d     (a_in[term_lsb(t, LANES, WIDTH) +: LW]),
      .q     (dot_a[term_lsb(t, LANES, WIDTH) +: LW])
    );

    tdot_skew #(.DEPTH(t), .W(LW)) u_skew_b (
      .clock (clock),
      .reset (reset),
      .en    (adv),
      .d     (b_in[term_lsb(t, LANES, WIDTH) +: LW]),
      .q     (dot_b[term_lsb(t, LANES, WIDTH) +: LW])
    );
  end

  tdot_skew #(.DEPTH(BIAS_SKEW), .W(LW)) u_skew_bias (
    .clock (clock),
    .reset (reset),
    .en    (adv),
    .d     (bias_in),
    .q     (dot_bias)
  );

  logic [PL-1:0] vld;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld <= '0;
    end else if (adv) begin
      vld <= {vld[PL-2:0], accept};
    end
  end

  assign m_valid = vld[PL-1];
  assign m_data  = dot_res;

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (accept && !done) begin
      count <= count + CW'(1);
    end else if (done && !accept) begin
      count <= count - CW'(1);
    end
  end

  assign busy = (count != '0);

`ifdef TDOT_FEEDER_PERF_EN
  // Stall cycles are counted even though the datapath itself is frozen.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_done  <= '0;
      perf_stall <= '0;
    end else begin
      if (done) perf_done <= perf_done + 32'd1;
      if (m_valid && !m_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: doc/tdot_feeder.md
Name: tdot_feeder

Overview:
- Producer/collector at the other end of the tdot systolic dot-product array.
- Accepts whole vector jobs (TERMS operand pairs plus one bias per lane) over a valid/ready handshake.
- Skews each term onto the array's per-term inputs, tracks each job's occupancy while it is in the array, and returns the array's results over a valid/ready handshake.
- Drives the array's enable so that downstream backpressure stalls the whole datapath without losing any job.

Parameters:
- WIDTH, 8: operand, bias and result bit width (signed).
- LANES, 5: number of independent dot-product lanes.
- TERMS, 3: terms per dot product.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  input job valid.
- s_ready  out  1  input job accepted when s_valid && s_ready.
- s_a  in  TERMS*LANES*WIDTH  a-operands; term t, lane l at [(t*LANES+l)*WIDTH +: WIDTH].
- s_b  in  TERMS*LANES*WIDTH  b-operands; same layout as s_a.
- s_bias  in  LANES*WIDTH  per-lane bias; lane l at [l*WIDTH +: WIDTH].
- dot_a  out  TERMS*LANES*WIDTH  skewed a-operands to the array.
- dot_b  out  TERMS*LANES*WIDTH  skewed b-operands to the array.
- dot_bias  out  LANES*WIDTH  skewed bias to the array.
- dot_en  out  1  array advance enable.
- dot_res  in  LANES*WIDTH  array result registers.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- m_data  out  LANES*WIDTH  result; equals dot_res.
- busy  out  1  at least one job in flight.

Behaviour:
- adv = !m_valid || m_ready.
  - dot_en = adv.
  - s_ready = adv.
  - Every internal register updates only when adv = 1.
- Skew, counted in advance cycles:
  - Term t of a job is presented on dot_a/dot_b t cycles after acceptance.
  - Bias is presented 2 cycles after acceptance.
  - Term 0 passes straight through combinationally from s_a/s_b, gated to zero on a bubble.
- Bubble: on an advance cycle with !s_valid, zeros are injected into the skew lines and a 0 valid bit into the tracker.
- Tracker: valid shift register of depth LAT = TERMS+2.
  - m_valid is the tail bit.
  - A result appears on m_data exactly LAT advance cycles after acceptance (5 with the defaults).
- Arithmetic is the array's, not re-computed here:
  - Products are truncated to WIDTH bits.
  - Sums wrap modulo 2^WIDTH.
  - All values are two's complement.
- Throughput: one job per cycle while m_ready = 1. Results leave in acceptance order, with bubbles preserved as gaps.
- Backpressure: while m_valid && !m_ready:
  - dot_en = 0 and s_ready = 0.
  - m_data, dot_a, dot_b and dot_bias hold stable.
  - No job is dropped or duplicated.
- Occupancy counter: 0..LAT, +1 on accept, -1 on m_valid && m_ready, no change when both occur in the same cycle. busy = (count != 0).
- Reset values:
  - m_valid = 0, busy = 0, s_ready = 1, dot_en = 1.
  - dot_a, dot_b and dot_bias drive 0, because all skew stages clear.
  - The counter clears.
- Reset mid-operation: all in-flight jobs are discarded and none is ever presented on m_valid. The array shares the same reset.

Optional Feature:
- Macro: TDOT_FEEDER_PERF_EN.
- When defined, adds two outputs, both clearing on reset and wrapping at 2^32:
  - perf_done [31:0]: counts m_valid && m_ready.
  - perf_stall [31:0]: counts cycles with m_valid && !m_ready.
- When undefined, these ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Package tdot_pkg holds:
  - WIDTH, LANES, TERMS defaults.
  - LAT = TERMS+2.
  - BIAS_SKEW = 2.
  - Lane/term slice index helper functions.
- Sub-module tdot_skew: enabled delay line with parameters DEPTH and W, synchronous reset to 0; DEPTH = 0 is a wire.
  - Instantiated per term (DEPTH = t) for a and b.
  - Instantiated once for bias (DEPTH = BIAS_SKEW).

Test Plan:
- Single job:
  - Stimulus: lane0 a = (1,2,3), b = (4,5,6), bias = 7; other lanes 0; m_ready = 1.
  - Response: m_valid pulses exactly 5 cycles after acceptance; lane0 = 39, other lanes = 0; busy returns to 0.
- Wrap and sign:
  - Stimulus: lane1 a = (127,127,127), b = (127,127,127), bias 0; lane2 a = (-1,-1,-1), b = (1,1,1), bias 0.
  - Response: lane1 = 3 (each product truncates to 1); lane2 = 0xFD.
- Streaming:
  - Stimulus: 8 back-to-back jobs with lane0 bias = k and zero operands, m_ready = 1.
  - Response: m_valid high for 8 consecutive cycles starting at cycle 5, m_data lane0 = 0..7 in order, s_ready never low.
- Backpressure:
  - Stimulus: m_ready low for 3 cycles when the first of 4 streamed results becomes valid.
  - Response: m_data stable, dot_en = 0, s_ready = 0 during the stall; afterwards all 4 results are delivered once, in order.
- Bubbles:
  - Stimulus: accept job, idle 2 cycles, accept job.
  - Response: results at cycles 5 and 8, with m_valid low at cycles 6 and 7.
- Reset mid-flight:
  - Stimulus: 3 jobs accepted, reset asserted at cycle 2.
  - Response: m_valid stays 0 for 10 cycles after reset; busy = 0; with TDOT_FEEDER_PERF_EN defined, perf_done = 0.
